fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: fetch PC, in-order request tracking, stale-response dropping and a prefetch queue.
// Optional macro FETCH_BYPASS_EN forwards a kept response straight to the output when the queue is empty.
module fetch_stage #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   qdata_q [DEPTH];
    logic [31:0]   qpc_q   [DEPTH];

    logic [31:0] target;
    logic [CW:0] inflight;
    logic        accept, rsp, keep, byp, push, pop;

    always_comb begin
        target        = redirect_pc & 32'hFFFF_FFFC;
        inflight      = {1'b0, outst_q} + {1'b0, count_q};
        imem_req      = reset && !redirect && (inflight < (CW+1)'(DEPTH));
        imem_addr     = fetch_pc_q;
        accept        = imem_req && imem_gnt;
        rsp           = reset && imem_rvalid;
        keep          = rsp && (drop_q == '0) && !redirect;
`ifdef FETCH_BYPASS_EN
        byp           = keep && (count_q == '0);
`else
        byp           = 1'b0;
`endif
        instr_valid   = reset && ((count_q != '0) || byp);
        instr         = byp ? imem_rdata : qdata_q[rd_ptr_q];
        instr_pc      = byp ? resp_pc_q : qpc_q[rd_ptr_q];
        instr_pcplus4 = instr_pc + 32'd4;
        pop           = reset && !redirect && (count_q != '0) && instr_ready;
        push          = keep && !(byp && instr_ready);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        outst_d    = outst_q + CW'(accept) - CW'(rsp);
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (keep) begin
            resp_pc_d = resp_pc_q + 32'd4;
        end
        if (rsp && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end
        // Every request still in flight after a redirect belongs to the abandoned path.
        if (redirect) begin
            fetch_pc_d = target;
            resp_pc_d  = target;
            count_d    = '0;
            drop_d     = outst_q - CW'(rsp);
            rd_ptr_d   = wr_ptr_q;
            wr_ptr_d   = wr_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qdata_q[wr_ptr_q] <= imem_rdata;
            qpc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order memory model plus a path/epoch reference of the fetch stream.
module tb_fetch_stage;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc, instr_pcplus4;

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .instr_pcplus4(instr_pcplus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] eaddr;
        int          due;
        int          ep;
    } mreq_t;

    mreq_t       memq[$];
    logic [31:0] liveq[$];
    int          checks = 0, errors = 0;
    int          cyc_n = 0, epoch = 0, last_due = 0;
    logic [31:0] next_pc = RESET_PC;
    logic [129:0] obs_vec, exp_vec;
    logic        o_req, o_valid, fire;
    logic [31:0] o_addr, o_instr, o_pc, o_p4;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    // One clock: drive inputs, sample outputs, form the expectation, advance the reference.
    task automatic cyc(input logic rn, input logic rdy, input logic g, input logic rd,
                       input logic [31:0] rpc, input int lat);
        logic rv, live, e_req, e_valid;
        logic [31:0] e_pc;
        mreq_t m;
        int due;
        @(negedge clk);
        reset = rn; instr_ready = rdy; imem_gnt = g; redirect = rd; redirect_pc = rpc;
        rv = 1'b0;
        if (rn && memq.size() > 0) rv = (memq[0].due <= cyc_n);
        imem_rvalid = rv;
        imem_rdata  = rv ? memfn(memq[0].addr) : $urandom();
        #1;
        live = rv && !rd && (memq[0].ep == epoch);
        e_req = rn && !rd && ((memq.size() + liveq.size()) < DEPTH);
        e_valid = rn && ((liveq.size() > 0) || (BYP && live));
        e_pc = 32'h0;
        if (liveq.size() > 0) e_pc = liveq[0];
        else if (live) e_pc = memq[0].eaddr;
        exp_vec = {e_req, e_req ? next_pc : 32'h0, e_valid,
                   e_valid ? {memfn(e_pc), e_pc, e_pc + 32'd4} : 96'h0};
        o_req = imem_req; o_addr = imem_addr; o_valid = instr_valid;
        o_instr = instr; o_pc = instr_pc; o_p4 = instr_pcplus4;
        obs_vec = {o_req, o_req ? o_addr : 32'h0, o_valid,
                   o_valid ? {o_instr, o_pc, o_p4} : 96'h0};
        fire = rn && o_valid && rdy && !rd;
        if (!rn) begin
            memq.delete(); liveq.delete();
            next_pc = RESET_PC; epoch++; last_due = 0;
        end else begin
            if (rv) begin
                m = memq.pop_front();
                if (live) liveq.push_back(m.eaddr);
            end
            if (e_valid && rdy && !rd) void'(liveq.pop_front());
            if (rd) begin
                epoch++; liveq.delete(); next_pc = rpc & 32'hFFFF_FFFC;
            end
            if (o_req && g) begin
                due = cyc_n + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                memq.push_back('{addr: o_addr, eaddr: next_pc, due: due, ep: epoch});
                next_pc = next_pc + 32'd4;
            end
        end
        cyc_n++;
    endtask

    task automatic apply_reset();
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1);
            checks++;
            if ({o_req, o_valid} !== 2'b00) begin
                errors++; $display("FAIL reset_outputs req/valid got=%b exp=00", {o_req, o_valid});
            end
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1);
        checks++;
        if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
            errors++; $display("FAIL reset_first_req got req=%b addr=%h exp req=1 addr=%h", o_req, o_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int k = 0;
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL stream_vec cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
            if (fire) begin
                checks++;
                if (o_pc !== RESET_PC + 32'(4 * k)) begin
                    errors++; $display("FAIL stream_pc got=%h exp=%h", o_pc, RESET_PC + 32'(4 * k));
                end
                k++;
            end
        end
        checks++;
        if (k != (BYP ? 23 : 22)) begin
            errors++; $display("FAIL stream_count got=%0d exp=%0d", k, BYP ? 23 : 22);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        logic [95:0] held = 96'h0;
        logic have = 1'b0;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL bp_vec cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
            if (o_req) acc++;
            if (o_valid && have) begin
                checks++;
                if ({o_instr, o_pc, o_p4} !== held) begin
                    errors++; $display("FAIL bp_stable got=%h exp=%h", {o_instr, o_pc, o_p4}, held);
                end
            end else if (o_valid) begin
                held = {o_instr, o_pc, o_p4}; have = 1'b1;
            end
        end
        checks++;
        if (acc != DEPTH || o_req !== 1'b0) begin
            errors++; $display("FAIL bp_requests got acc=%0d req=%b exp acc=%0d req=0", acc, o_req, DEPTH);
        end
        checks++;
        if (o_valid !== 1'b1 || o_pc !== RESET_PC || o_p4 !== RESET_PC + 32'd4) begin
            errors++; $display("FAIL bp_head got valid=%b pc=%h exp valid=1 pc=%h", o_valid, o_pc, RESET_PC);
        end
    endtask

    task automatic test_redirect();
        logic got = 1'b0;
        logic [31:0] fpc = 32'h0, fp4 = 32'h0;
        apply_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 3);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100, 3);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 3);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL redir_vec cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
            if (i == 0) begin
                checks++;
                if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h100) begin
                    errors++; $display("FAIL redir_next got valid=%b req=%b addr=%h exp 0 1 00000100", o_valid, o_req, o_addr);
                end
            end
            if (fire && !got) begin
                got = 1'b1; fpc = o_pc; fp4 = o_p4;
            end
        end
        checks++;
        if (!got || fpc !== 32'h100 || fp4 !== 32'h104) begin
            errors++; $display("FAIL redir_first got=%b pc=%h p4=%h exp pc=00000100 p4=00000104", got, fpc, fp4);
        end
    endtask

    task automatic test_double_redirect();
        logic got = 1'b0;
        logic [31:0] fpc = 32'h0;
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 3);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 3);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 3);
        if (fire) bad++;
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 3);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 3);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL dbl_vec cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
            if (fire && o_pc < 32'h300) bad++;
            if (fire && !got) begin
                got = 1'b1; fpc = o_pc;
            end
        end
        checks++;
        if (!got || fpc !== 32'h300 || bad != 0) begin
            errors++; $display("FAIL dbl_first got=%b pc=%h stale=%0d exp pc=00000300 stale=0", got, fpc, bad);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        logic [31:0] pcs[2];
        logic [31:0] p4s[2];
        apply_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1);
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL wrap_vec cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
            if (fire && n < 2) begin
                pcs[n] = o_pc; p4s[n] = o_p4; n++;
            end
        end
        checks++;
        if (n != 2 || pcs[0] !== 32'hFFFF_FFFC || p4s[0] !== 32'h0 || pcs[1] !== 32'h0) begin
            errors++; $display("FAIL wrap_seq got n=%0d pc0=%h p40=%h pc1=%h exp FFFFFFFC 00000000 00000000", n, pcs[0], p4s[0], pcs[1]);
        end
    endtask

    task automatic test_midreset();
        apply_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1);
        checks++;
        if (o_valid !== 1'b1 || o_req !== 1'b0) begin
            errors++; $display("FAIL mid_full got valid=%b req=%b exp valid=1 req=0", o_valid, o_req);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1);
            checks++;
            if ({o_valid, o_req} !== 2'b00) begin
                errors++; $display("FAIL mid_reset got valid/req=%b exp=00", {o_valid, o_req});
            end
        end
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1);
        checks++;
        if (o_req !== 1'b1 || o_addr !== RESET_PC || o_valid !== 1'b0) begin
            errors++; $display("FAIL mid_release got req=%b addr=%h valid=%b exp 1 %h 0", o_req, o_addr, o_valid, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic prev_hold = 1'b0;
        logic [95:0] prev = 96'h0;
        logic rdy, g, rd;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 2) != 0);
            g   = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            cyc(1'b1, rdy, g, rd, $urandom(), $urandom_range(1, 4));
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++; $display("FAIL rand_vec cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            end
            if (prev_hold) begin
                checks++;
                if (o_valid !== 1'b1 || {o_instr, o_pc, o_p4} !== prev) begin
                    errors++; $display("FAIL rand_stable cyc=%0d got=%h exp=%h", i, {o_instr, o_pc, o_p4}, prev);
                end
            end
            prev_hold = o_valid && !rdy && !rd;
            prev = {o_instr, o_pc, o_p4};
        end
    endtask

    initial begin
        reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_double_redirect();
        test_wrap();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
